// File: rtl/cache_refill_controller.sv
// Request sequencer in front of a direct-mapped cache: issues core requests,
// refills missing lines block by block from backing memory, then replays.
module cache_refill_controller #(
    parameter int BLOCK_SIZE             = 4,
    parameter int NUM_OF_BLOCKS_PER_LINE = 2,
    parameter int ADDRESS_SIZE           = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,

    input  logic                                     cpu_read,
    input  logic                                     cpu_write,
    input  logic [ADDRESS_SIZE-1:0]                  cpu_address,
    input  logic [BLOCK_SIZE-1:0]                    cpu_data_i,
    output logic [BLOCK_SIZE-1:0]                    cpu_data_o,
    output logic                                     cpu_ready,
    output logic                                     cpu_error,
    output logic                                     busy,

    output logic                                     cache_read,
    output logic                                     cache_write,
    output logic                                     cache_write_line,
    output logic [ADDRESS_SIZE-1:0]                  cache_address,
    output logic [BLOCK_SIZE-1:0]                    cache_data_i,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] cache_line_i,
    input  logic [BLOCK_SIZE-1:0]                    cache_data_o,
    input  logic                                     cache_hit,
    input  logic                                     cache_miss,

    output logic                                     mem_req_valid,
    input  logic                                     mem_req_ready,
    output logic [ADDRESS_SIZE-1:0]                  mem_req_address,
    input  logic                                     mem_rsp_valid,
    input  logic [BLOCK_SIZE-1:0]                    mem_rsp_data
);

    localparam int OFFSET_LEN = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int LINE_W     = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
    localparam int BASE_W     = ADDRESS_SIZE - OFFSET_LEN;
    localparam logic [OFFSET_LEN-1:0] LAST_BLK = OFFSET_LEN'(NUM_OF_BLOCKS_PER_LINE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_RESP      = 3'd3;
    localparam logic [2:0] S_FETCH_REQ = 3'd4;
    localparam logic [2:0] S_FETCH_RSP = 3'd5;
    localparam logic [2:0] S_FILL      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]              r_state;
    logic                    r_is_write;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [BLOCK_SIZE-1:0]   r_wdata;
    logic [BLOCK_SIZE-1:0]   r_rdata;
    logic [OFFSET_LEN-1:0]   r_cnt;
    logic                    r_replay;
    logic                    r_error;
    logic [LINE_W-1:0]       r_line;

    logic [BASE_W-1:0]       w_base;
    logic                    w_issue;
    logic                    w_fill;
    logic                    w_fetch;

    assign w_base  = r_addr[ADDRESS_SIZE-1:OFFSET_LEN];
    assign w_issue = (r_state == S_ISSUE);
    assign w_fill  = (r_state == S_FILL);
    assign w_fetch = (r_state == S_FETCH_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_replay   <= 1'b0;
            r_error    <= 1'b0;
            r_line     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_read || cpu_write) begin
                        // A simultaneous read and write is treated as a read.
                        r_is_write <= ~cpu_read;
                        r_addr     <= cpu_address;
                        r_wdata    <= cpu_data_i;
                        r_error    <= 1'b0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT:  r_state <= S_RESP;
                S_RESP: begin
                    if (cache_hit) begin
                        if (!r_is_write) begin
                            r_rdata <= cache_data_o;
                        end
                        r_error <= 1'b0;
                        r_state <= S_DONE;
                    end else if (cache_miss) begin
                        // A miss on the replay means the fill did not take; report it.
                        if (r_replay) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_FETCH_REQ;
                        end
                    end
                end
                S_FETCH_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_FETCH_RSP;
                    end
                end
                S_FETCH_RSP: begin
                    if (mem_rsp_valid) begin
                        for (int k = 0; k < NUM_OF_BLOCKS_PER_LINE; k++) begin
                            if (r_cnt == OFFSET_LEN'(k)) begin
                                r_line[k*BLOCK_SIZE +: BLOCK_SIZE] <= mem_rsp_data;
                            end
                        end
                        if (r_cnt == LAST_BLK) begin
                            r_state <= S_FILL;
                        end else begin
                            r_cnt   <= r_cnt + OFFSET_LEN'(1);
                            r_state <= S_FETCH_REQ;
                        end
                    end
                end
                S_FILL: begin
                    r_replay <= 1'b1;
                    r_state  <= S_ISSUE;
                end
                S_DONE: begin
                    r_replay <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset forces them low at once.
    assign busy             = (r_state != S_IDLE);
    assign cpu_ready        = (r_state == S_DONE);
    assign cpu_error        = (r_state == S_DONE) && r_error;
    assign cpu_data_o       = r_rdata;

    assign cache_read       = w_issue && !r_is_write;
    assign cache_write      = w_issue && r_is_write;
    assign cache_write_line = w_fill;
    assign cache_address    = w_issue ? r_addr :
                              w_fill  ? {w_base, {OFFSET_LEN{1'b0}}} : '0;
    assign cache_data_i     = (w_issue && r_is_write) ? r_wdata : '0;
    assign cache_line_i     = w_fill ? r_line : '0;

    assign mem_req_valid    = w_fetch;
    assign mem_req_address  = w_fetch ? {w_base, r_cnt} : '0;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller with behavioural models of a
// 4-line direct-mapped cache and a block-per-request backing memory.
module tb_cache_refill_controller;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  line;
    } fill_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_address;
    logic [3:0]  cpu_data_i, cpu_data_o;
    logic        cpu_ready, cpu_error, busy;
    logic        cache_read, cache_write, cache_write_line;
    logic [15:0] cache_address;
    logic [3:0]  cache_data_i, cache_data_o;
    logic [7:0]  cache_line_i;
    logic        cache_hit, cache_miss;
    logic        mem_req_valid, mem_req_ready;
    logic [15:0] mem_req_address;
    logic        mem_rsp_valid;
    logic [3:0]  mem_rsp_data;

    bit   rand_phase = 1'b1;
    bit   mem_auto = 1'b1;
    int   late_req = 0;
    int   late_done = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_memhs = 0;
    int   rdy_edge = 0;
    int   acc_edge = 0;
    int   done_target = 0;
    logic [3:0] exp_last_rd = 4'h0;

    rsp_t        exp_rsp[$];
    logic [15:0] exp_mem[$];
    fill_t       exp_fill[$];

    cache_refill_controller #(
        .BLOCK_SIZE(4), .NUM_OF_BLOCKS_PER_LINE(2), .ADDRESS_SIZE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_ready(cpu_ready),
        .cpu_error(cpu_error), .busy(busy),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_write_line(cache_write_line), .cache_address(cache_address),
        .cache_data_i(cache_data_i), .cache_line_i(cache_line_i),
        .cache_data_o(cache_data_o), .cache_hit(cache_hit), .cache_miss(cache_miss),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_address(mem_req_address), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, cpu_data_o, cpu_ready, cpu_error, busy, cache_read, cache_write,
                cache_write_line, cache_address, cache_data_i, cache_line_i,
                mem_req_valid, mem_req_address};
    endfunction

    function automatic logic [3:0] memval(input logic [15:0] a);
        case (a)
            16'h0004: return 4'hA;
            16'h0005: return 4'h5;
            16'h0008: return 4'h7;
            16'h0009: return 4'hC;
            16'h000C: return 4'h1;
            16'h000D: return 4'h2;
            default:  return 4'h0;
        endcase
    endfunction

    // Cache model: lookup result appears at the start of the controller's RESP cycle.
    initial begin : cache_model
        bit         cvalid[4];
        logic [12:0] ctag[4];
        logic [3:0] cblk[4][2];
        logic [1:0] idx;
        logic       off, hit;
        logic [3:0] rd;
        cache_hit = 1'b0; cache_miss = 1'b0; cache_data_o = 4'h0;
        while (rand_phase) begin
            cache_hit = 1'($urandom); cache_miss = 1'($urandom); cache_data_o = 4'($urandom);
            @(negedge clk);
        end
        cache_hit = 1'b0; cache_miss = 1'b0; cache_data_o = 4'h0;
        forever begin
            @(negedge clk);
            idx = cache_address[2:1];
            off = cache_address[0];
            if (cache_write_line) begin
                cvalid[idx]  = 1'b1;
                ctag[idx]    = cache_address[15:3];
                cblk[idx][0] = cache_line_i[3:0];
                cblk[idx][1] = cache_line_i[7:4];
            end else if (cache_read || cache_write) begin
                hit = cvalid[idx] && (ctag[idx] == cache_address[15:3]);
                rd  = hit ? cblk[idx][off] : 4'h0;
                if (hit && cache_write) cblk[idx][off] = cache_data_i;
                @(posedge clk); #1;
                cache_hit = 1'b0; cache_miss = 1'b0;
                @(posedge clk); #1;
                cache_hit = hit; cache_miss = !hit; cache_data_o = rd;
            end
        end
    end

    // Backing memory: one response one cycle after each accepted request.
    initial begin : mem_model
        logic [3:0] d;
        mem_rsp_valid = 1'b0; mem_rsp_data = 4'h0;
        while (rand_phase) begin
            mem_rsp_valid = 1'($urandom); mem_rsp_data = 4'($urandom);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0; mem_rsp_data = 4'h0;
        forever begin
            @(negedge clk);
            if (late_req != late_done) begin
                @(posedge clk); #1;
                mem_rsp_valid = 1'b1; mem_rsp_data = 4'hF;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
                late_done++;
            end else if (mem_auto && mem_req_valid && mem_req_ready) begin
                d = memval(mem_req_address);
                @(posedge clk); #1;
                mem_rsp_valid = 1'b1; mem_rsp_data = d;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        rsp_t  r;
        fill_t f;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_ready) begin
                    rdy_edge = cyc + 1;
                    n_done++;
                    chk("rsp_expected", 64'(exp_rsp.size() > 0), 64'd1);
                    if (exp_rsp.size() > 0) begin
                        r = exp_rsp.pop_front();
                        chk("cpu_data_o", 64'(cpu_data_o), 64'(r.data));
                        chk("cpu_error", 64'(cpu_error), 64'(r.err));
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    n_memhs++;
                    chk("mem_req_expected", 64'(exp_mem.size() > 0), 64'd1);
                    if (exp_mem.size() > 0) begin
                        a = exp_mem.pop_front();
                        chk("mem_req_address", 64'(mem_req_address), 64'(a));
                    end
                end
                if (cache_write_line) begin
                    chk("fill_expected", 64'(exp_fill.size() > 0), 64'd1);
                    if (exp_fill.size() > 0) begin
                        f = exp_fill.pop_front();
                        chk("fill_address", 64'(cache_address), 64'(f.addr));
                        chk("fill_line", 64'(cache_line_i), 64'(f.line));
                    end
                end
            end
        end
    end

    task automatic push_read(input logic [3:0] d);
        exp_rsp.push_back({d, 1'b0});
        exp_last_rd = d;
        done_target++;
    endtask

    task automatic push_write();
        exp_rsp.push_back({exp_last_rd, 1'b0});
        done_target++;
    endtask

    task automatic push_refill(input logic [15:0] base, input logic [7:0] line);
        exp_mem.push_back(base);
        exp_mem.push_back(base | 16'h0001);
        exp_fill.push_back({base, line});
    endtask

    task automatic req(input bit wr, input logic [15:0] a, input logic [3:0] d);
        @(posedge clk); #1;
        chk("idle_before_req", 64'(busy), 64'd0);
        cpu_read = !wr; cpu_write = wr; cpu_address = a; cpu_data_i = d;
        @(posedge clk); #1;
        acc_edge = cyc;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 16'h0; cpu_data_i = 4'h0;
        chk("req_accepted_busy", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (n_done >= done_target) break;
            @(negedge clk);
        end
        chk("completion_in_time", 64'(n_done >= done_target), 64'd1);
    endtask

    task automatic wait_mem_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_valid) break;
        end
        chk("mem_req_valid_seen", 64'(mem_req_valid), 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int hs0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 16'h0; cpu_data_i = 4'h0;
        mem_req_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cpu_read = 1'($urandom); cpu_write = 1'($urandom);
            cpu_address = 16'($urandom); cpu_data_i = 4'($urandom);
            mem_req_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs_zero", all_outs(), 64'd0);
            chk("reset_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        rand_phase = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 16'h0; cpu_data_i = 4'h0;
        mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Read miss on 0x0004.
        push_refill(16'h0004, 8'h5A);
        push_read(4'hA);
        req(1'b0, 16'h0004, 4'h0);
        wait_done();

        // Read hit on 0x0005: four-edge latency, no memory traffic.
        hs0 = n_memhs;
        push_read(4'h5);
        req(1'b0, 16'h0005, 4'h0);
        wait_done();
        chk("hit_latency", 64'(rdy_edge - acc_edge), 64'd4);
        chk("hit_no_mem_traffic", 64'(n_memhs - hs0), 64'd0);

        // Write miss on 0x0008, then read it back through a hit.
        push_refill(16'h0008, 8'hC7);
        push_write();
        req(1'b1, 16'h0008, 4'h3);
        wait_done();
        push_read(4'h3);
        req(1'b0, 16'h0008, 4'h0);
        wait_done();
        chk("readback_latency", 64'(rdy_edge - acc_edge), 64'd4);

        // Evict index 2 so 0x0004 misses again.
        push_refill(16'h000C, 8'h21);
        push_read(4'h1);
        req(1'b0, 16'h000C, 4'h0);
        wait_done();

        // Backpressure: ready low for five FETCH_REQ cycles.
        mem_req_ready = 1'b0;
        push_refill(16'h0004, 8'h5A);
        push_read(4'hA);
        req(1'b0, 16'h0004, 4'h0);
        wait_mem_valid();
        chk("bp_addr", 64'(mem_req_address), 64'h0004);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(mem_req_valid), 64'd1);
            chk("bp_addr_held", 64'(mem_req_address), 64'h0004);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", 64'(mem_req_valid && mem_req_ready), 64'd1);
        @(negedge clk);
        chk("bp_valid_dropped", 64'(mem_req_valid), 64'd0);
        wait_done();

        // Evict again ahead of the reset test.
        push_refill(16'h000C, 8'h21);
        push_read(4'h1);
        req(1'b0, 16'h000C, 4'h0);
        wait_done();

        // Reset while waiting for a memory response.
        mem_auto = 1'b0;
        exp_mem.push_back(16'h0004);
        req(1'b0, 16'h0004, 4'h0);
        wait_mem_valid();
        @(posedge clk); #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        chk("pre_reset_in_fetch_rsp", 64'(mem_req_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_last_rd = 4'h0;
        late_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_rsp_idle_outputs", all_outs(), 64'd0);
        end
        chk("late_rsp_driven", 64'(late_done), 64'(late_req));

        // Fresh read restarts the fetch from block 0.
        mem_auto = 1'b1;
        push_refill(16'h0004, 8'h5A);
        push_read(4'hA);
        req(1'b0, 16'h0004, 4'h0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        chk("fill_queue_drained", 64'(exp_fill.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
